conv_rowgroup_engine: RTL
=========================

# conv_rowgroup_engine

Parametrised convolution row engine: the successor to the fixed 12-lane, 3-row convolution layer. Each beat computes one KH-row filter dot product per output row over LANES lanes. It accumulates these over a run-time group length (input channels) with ready/valid backpressure on both sides and an early close on `pool_end`. Results pass through optional ReLU and saturation before being handed to the pooling stage.

## Interface
- LANES, 12, multiply lanes per row
- DW, 8, activation width (unsigned)
- WW, 4, weight width (signed two's complement)
- KH, 3, filter rows
- ROWS_IN, 4, input rows per beat; OUT_ROWS = ROWS_IN-KH+1
- ACC_MAX, 8, maximum beats per group
- PSW, 24, accumulator width; must be ≥ DW+WW+1+clog2(KH*LANES*ACC_MAX)
- OW, 16, output width per row (signed)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enables beat acceptance
- din_valid  in  1  input beat valid
- din_ready  out  1  combinational: en & state∈{IDLE,ACC}
- data_in  in  ROWS_IN*LANES*DW  row r lane l at [(r*LANES+l)*DW +: DW]
- filt_in  in  KH*LANES*WW  row k lane l at [(k*LANES+l)*WW +: WW]
- acc_len  in  clog2(ACC_MAX+1)  beats per group, sampled on first beat; 0 treated as 1, >ACC_MAX clamped
- relu_en  in  1  sampled on first beat of group
- pool_end  in  1  closes current group early
- psum_out  out  OUT_ROWS*OW  row r at [r*OW +: OW]
- dout_valid  out  1  result valid
- dout_ready  in  1  consumer accepts
- dout_partial  out  1  group closed by pool_end
- conv_counter  out  3  completed groups, mod 8

## Operation
- Beat accepted when din_valid & din_ready.
- Per output row r: beat_sum[r] = Σ_{k<KH} Σ_{l<LANES} data[r+k][l] * filt[k][l]; unsigned×signed, sign-extended to PSW.
- Pipeline: E0 products registered; E1 row sums registered; E2 accumulator updated.
- FSM:
  - IDLE: on first accepted beat, latch acc_len/relu_en, clear beat count, → ACC. If that beat completes the group (len 1) or pool_end is high, → DRAIN instead.
  - ACC: count accepted beats. When count reaches len, or pool_end is high (beat in the same cycle is included), → DRAIN. pool_end with no beat that cycle also → DRAIN.
  - DRAIN: din_ready=0. Wait until the pipeline is empty, then load the output register → OUT.
  - OUT: dout_valid=1, psum_out/dout_partial held stable. On dout_ready: clear accumulators, conv_counter+1 (wraps 7→0), → IDLE.
- Output per row: if relu_en and acc<0 → 0. Then saturate to [-2^(OW-1), 2^(OW-1)-1].
- dout_partial=1 iff pool_end closed the group before len beats.
- pool_end in IDLE, DRAIN or OUT is ignored.
- en low blocks acceptance only; the pipeline, DRAIN and OUT proceed.

## Timing
- Reset: state IDLE; psum_out=0, dout_valid=0, dout_partial=0, conv_counter=0; pipeline valids and accumulators cleared. din_ready follows en after release.
- Reset mid-group: partial sums discarded; no dout_valid is produced.
- Latency: dout_valid rises 3 cycles after the edge that samples the last beat (or the pool_end close).
- Throughput: a group of N beats occupies N + 3 + (≥1 OUT) cycles. No overlap of groups.
- dout_valid & dout_ready: handshake completes at that edge, and dout_valid is low next cycle. din_ready rises the same cycle (IDLE).
- din_valid gaps inside ACC are allowed; the beat count only advances on acceptance.

## Test plan
- All data=1, all weights=1, LANES=12, KH=3, acc_len=4, dout_ready=1 -> each row 144, dout_partial=0, dout_valid 3 cycles after 4th beat, conv_counter 0→1.
- Weights=4'hF (−1), data=1, acc_len=4 -> relu_en=0: each row −144; relu_en=1: each row 0.
- Data=255, weights=7, acc_len=8 -> raw 514080 saturates to 32767 per row. Weights=−8 gives −32768.
- Ones stimulus, acc_len=4, pool_end with 2nd beat -> rows 72, dout_partial=1. pool_end asserted in IDLE -> no output.
- dout_ready low 5 cycles during OUT -> din_ready=0, psum_out stable, conv_counter unchanged until handshake. 8 groups -> conv_counter wraps to 0.
- rst_n pulsed after 2 beats of a 4-beat group -> all outputs 0. Next full group gives 144 with no residue. acc_len=0 -> single-beat group giving 36.

Source files
------------

// File: rtl/conv_rowgroup_if.sv
// Beat-in / result-out bundle for conv_rowgroup_engine.
// The producer/consumer side uses master; the engine uses slave.
interface conv_rowgroup_if #(
   parameter int LANES   = 12,
   parameter int DW      = 8,
   parameter int WW      = 4,
   parameter int KH      = 3,
   parameter int ROWS_IN = 4,
   parameter int ACC_MAX = 8,
   parameter int OW      = 16
);
   localparam int OUT_ROWS = ROWS_IN - KH + 1;
   localparam int ALW      = $clog2(ACC_MAX + 1);

   logic                        en;
   logic                        din_valid;
   logic                        din_ready;
   logic [ROWS_IN*LANES*DW-1:0] data_in;
   logic [KH*LANES*WW-1:0]      filt_in;
   logic [ALW-1:0]              acc_len;
   logic                        relu_en;
   logic                        pool_end;
   logic [OUT_ROWS*OW-1:0]      psum_out;
   logic                        dout_valid;
   logic                        dout_ready;
   logic                        dout_partial;
   logic [2:0]                  conv_counter;

   modport master (
      output en, din_valid, data_in, filt_in, acc_len, relu_en, pool_end, dout_ready,
      input  din_ready, psum_out, dout_valid, dout_partial, conv_counter
   );

   modport slave (
      input  en, din_valid, data_in, filt_in, acc_len, relu_en, pool_end, dout_ready,
      output din_ready, psum_out, dout_valid, dout_partial, conv_counter
   );
endinterface

// File: rtl/conv_rowgroup_engine.sv
// Convolution row engine: KH-row dot products per output row, accumulated over a
// run-time group of beats, then ReLU/saturated and handed off with ready/valid.
module conv_rowgroup_engine #(
   parameter int LANES   = 12,
   parameter int DW      = 8,
   parameter int WW      = 4,
   parameter int KH      = 3,
   parameter int ROWS_IN = 4,
   parameter int ACC_MAX = 8,
   parameter int PSW     = 24,
   parameter int OW      = 16
) (
   input logic          clk,
   input logic          rst_n,
   conv_rowgroup_if.slave bus
);
   localparam int OUT_ROWS = ROWS_IN - KH + 1;
   localparam int ALW      = $clog2(ACC_MAX + 1);
   localparam int PW       = DW + WW + 1;
   localparam logic signed [PSW-1:0] SAT_HI = PSW'((2 ** (OW - 1)) - 1);
   localparam logic signed [PSW-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

   state_t                state, state_nx;
   logic                  accept, din_ready, load_out, hs_done;
   logic                  close_full, close_early;
   logic [ALW-1:0]        len_in, len_q, cnt_q, cnt_inc;
   logic                  relu_q, partial_q, partial_out;
   logic [1:0]            drain_cnt;
   logic                  v0, v1;
   logic signed [PW-1:0]  prod_c [OUT_ROWS][KH][LANES];
   logic signed [PW-1:0]  prod_q [OUT_ROWS][KH][LANES];
   logic signed [PSW-1:0] sum_c  [OUT_ROWS];
   logic signed [PSW-1:0] sum_q  [OUT_ROWS];
   logic signed [PSW-1:0] acc_q  [OUT_ROWS];
   logic [OUT_ROWS*OW-1:0] psum_q;
   logic [2:0]            conv_cnt;

   function automatic logic [OW-1:0] post_proc(input logic signed [PSW-1:0] a, input logic relu);
      logic signed [PSW-1:0] v;
      v = (relu && a < 0) ? '0 : a;
      if (v > SAT_HI) return SAT_HI[OW-1:0];
      if (v < SAT_LO) return SAT_LO[OW-1:0];
      return v[OW-1:0];
   endfunction

   assign accept  = bus.din_valid & din_ready;
   assign cnt_inc = cnt_q + ALW'(1);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      len_in = bus.acc_len;
      if (bus.acc_len == '0)
         len_in = ALW'(1);
      else if (bus.acc_len > ALW'(ACC_MAX))
         len_in = ALW'(ACC_MAX);
   end

   // A beat arriving with pool_end on the final count closes the group as complete.
   assign close_full  = accept && ((state == IDLE && len_in == ALW'(1)) ||
                                   (state == ACC  && cnt_inc == len_q));
   assign close_early = bus.pool_end && !close_full &&
                        ((state == IDLE && accept) || state == ACC);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (accept) state_nx = (close_full || close_early) ? DRAIN : ACC;
         ACC:   if (close_full || close_early) state_nx = DRAIN;
         DRAIN: if (load_out) state_nx = OUT;
         OUT:   if (hs_done) state_nx = IDLE;
      endcase
   end

   always_comb begin
      din_ready = 1'b0;
      load_out  = 1'b0;
      hs_done   = 1'b0;
      unique case (state)
         IDLE, ACC: din_ready = bus.en;
         DRAIN:     load_out  = (drain_cnt == 2'd2) && !v0 && !v1;
         OUT:       hs_done   = bus.dout_ready;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q     <= '0;
         cnt_q     <= '0;
         relu_q    <= 1'b0;
         partial_q <= 1'b0;
         drain_cnt <= 2'd0;
      end else begin
         if (state == IDLE && accept) begin
            len_q  <= len_in;
            relu_q <= bus.relu_en;
            cnt_q  <= ALW'(1);
         end else if (state == ACC && accept) begin
            cnt_q <= cnt_inc;
         end
         if (close_full || close_early) partial_q <= close_early;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      end
   end

   always_comb begin
      for (int r = 0; r < OUT_ROWS; r++) begin
         sum_c[r] = '0;
         for (int k = 0; k < KH; k++) begin
            for (int l = 0; l < LANES; l++) begin
               prod_c[r][k][l] =
                  signed'({{(PW-DW){1'b0}}, bus.data_in[((r+k)*LANES+l)*DW +: DW]}) *
                  signed'({{(PW-WW){bus.filt_in[(k*LANES+l)*WW + WW-1]}},
                           bus.filt_in[(k*LANES+l)*WW +: WW]});
               sum_c[r] = sum_c[r] + PSW'(prod_q[r][k][l]);
            end
         end
      end
   end

   // NOTE: datapath stages carry no reset; their valid bits gate every use.
   always_ff @(posedge clk) begin
      if (accept) prod_q <= prod_c;
      if (v0)     sum_q  <= sum_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0          <= 1'b0;
         v1          <= 1'b0;
         psum_q      <= '0;
         partial_out <= 1'b0;
         conv_cnt    <= 3'd0;
         for (int r = 0; r < OUT_ROWS; r++) acc_q[r] <= '0;
      end else begin
         v0 <= accept;
         v1 <= v0;
         if (hs_done) begin
            conv_cnt <= conv_cnt + 3'd1;
            for (int r = 0; r < OUT_ROWS; r++) acc_q[r] <= '0;
         end else if (v1) begin
            for (int r = 0; r < OUT_ROWS; r++) acc_q[r] <= acc_q[r] + sum_q[r];
         end
         if (load_out) begin
            partial_out <= partial_q;
            for (int r = 0; r < OUT_ROWS; r++) psum_q[r*OW +: OW] <= post_proc(acc_q[r], relu_q);
         end
      end
   end

   assign bus.din_ready    = din_ready;
   assign bus.psum_out     = psum_q;
   assign bus.dout_valid   = (state == OUT);
   assign bus.dout_partial = partial_out;
   assign bus.conv_counter = conv_cnt;
endmodule
